hazard_ctrl: RTL and testbench

- Pipeline control block that drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- It consumes the decoded fields that the ID/EX latch carries forward (EX-stage destination, memread, branch/jump resolution) and compares them against the ID-stage instruction.
- It inserts load-use bubbles, squashes wrong-path instructions, freezes the pipe on data-memory waits and holds a sticky halt.
- Two saturating event counters are provided for performance debug.

---
 rtl/hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch squash, dmem-wait freeze,
// sticky halt, plus saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_wsel,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_pcsrc,
  input  logic             mem_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             memreq, lduse, squash;

  assign memreq = mem_dREN | mem_dWEN;
  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign lduse  = ex_memread & (ex_wsel != 5'd0) &
                  ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (mem_halt)           state_d = HALT;
        else if (memreq && !dhit) state_d = DWAIT;
      end
      DWAIT:   if (dhit) state_d = RUN;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    memwb_flush = 1'b0;
    halt        = 1'b0;
    squash      = 1'b0;
    if (nRST) begin
      unique case (state_q)
        RUN: begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
          if (mem_halt) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
          end else if (memreq && !dhit) begin
            {pc_en, ifid_en, idex_en, exmem_en} = '0;
            memwb_flush = 1'b1;
          end else if (ex_pcsrc) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            squash     = 1'b1;
          end else if (lduse) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
          end
        end
        DWAIT: begin
          memwb_en = 1'b1;
          if (dhit) {pc_en, ifid_en, idex_en, exmem_en} = '1;
          else      memwb_flush = 1'b1;
        end
        HALT:    halt = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && state_q != HALT && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (squash && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;
  localparam int unsigned CNT_W = 16;

  logic CLK = 1'b0, nRST = 1'b0;
  logic ihit, dhit, id_uses_rt, ex_memread, mem_dREN, mem_dWEN, ex_pcsrc, mem_halt;
  logic [4:0] id_rs, id_rt, ex_wsel;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_flush, halt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [7:0] ctl;
  int total = 0;
  int bad = 0;

  localparam logic [7:0] C_ZERO   = 8'b00000000;
  localparam logic [7:0] C_ALL    = 8'b11010110;
  localparam logic [7:0] C_LDUSE  = 8'b00011110;
  localparam logic [7:0] C_BRANCH = 8'b11111110;
  localparam logic [7:0] C_NOIHIT = 8'b01110110;
  localparam logic [7:0] C_FREEZE = 8'b00000011;

  assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_flush};

  always #5 CLK = ~CLK;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_memread(ex_memread), .ex_wsel(ex_wsel),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_pcsrc(ex_pcsrc), .mem_halt(mem_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .memwb_flush(memwb_flush), .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0;
    ex_memread = 1'b0; ex_wsel = 5'd0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
    ex_pcsrc = 1'b0; mem_halt = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      {ihit, dhit, id_uses_rt, ex_memread, mem_dREN, mem_dWEN, ex_pcsrc, mem_halt} = 8'($urandom);
      id_rs = 5'($urandom); id_rt = 5'($urandom); ex_wsel = 5'($urandom);
      #1;
      total++; if (ctl !== C_ZERO) begin bad++; $display("FAIL reset_ctl: got %b want %b", ctl, C_ZERO); end
    end
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL reset_halt: got %b want 0", halt); end
    total++; if (stall_cnt !== '0 || flush_cnt !== '0) begin bad++;
      $display("FAIL reset_cnt: got stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt); end
    @(negedge CLK); idle(); nRST = 1'b1; #1;
    total++; if (ctl !== C_ALL) begin bad++; $display("FAIL reset_release: got %b want %b", ctl, C_ALL); end
  endtask

  task automatic test_loaduse();
    @(negedge CLK); idle(); ex_memread = 1'b1; ex_wsel = 5'd8; id_rs = 5'd8; #1;
    total++; if (ctl !== C_LDUSE) begin bad++; $display("FAIL lduse_rs: got %b want %b", ctl, C_LDUSE); end
    @(negedge CLK); idle(); #1;
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lduse_cnt: got %0d want 1", stall_cnt); end
    total++; if (ctl !== C_ALL) begin bad++; $display("FAIL lduse_clear: got %b want %b", ctl, C_ALL); end
    @(negedge CLK); idle(); ex_memread = 1'b1; ex_wsel = 5'd0; id_rs = 5'd0; #1;
    total++; if (ctl !== C_ALL) begin bad++; $display("FAIL lduse_r0: got %b want %b", ctl, C_ALL); end
    @(negedge CLK); idle(); ex_memread = 1'b1; ex_wsel = 5'd9; id_rs = 5'd3; id_rt = 5'd9; #1;
    total++; if (ctl !== C_ALL) begin bad++; $display("FAIL lduse_rt_unused: got %b want %b", ctl, C_ALL); end
    id_uses_rt = 1'b1; #1;
    total++; if (ctl !== C_LDUSE) begin bad++; $display("FAIL lduse_rt: got %b want %b", ctl, C_LDUSE); end
    @(negedge CLK); idle(); #1;
    total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL lduse_cnt2: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_branch();
    @(negedge CLK); idle(); ex_memread = 1'b1; ex_wsel = 5'd8; id_rs = 5'd8; ex_pcsrc = 1'b1; #1;
    total++; if (ctl !== C_BRANCH) begin bad++; $display("FAIL branch_ctl: got %b want %b", ctl, C_BRANCH); end
    @(negedge CLK); idle(); ihit = 1'b0; ex_pcsrc = 1'b1; #1;
    total++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd2) begin bad++;
      $display("FAIL branch_cnt: got flush=%0d stall=%0d want 1 2", flush_cnt, stall_cnt); end
    total++; if (ctl !== C_BRANCH) begin bad++; $display("FAIL branch_noihit: got %b want %b", ctl, C_BRANCH); end
    @(negedge CLK); idle(); ihit = 1'b0; #1;
    total++; if (flush_cnt !== 16'd2) begin bad++; $display("FAIL branch_cnt2: got %0d want 2", flush_cnt); end
    total++; if (ctl !== C_NOIHIT) begin bad++; $display("FAIL ihit_miss: got %b want %b", ctl, C_NOIHIT); end
    @(negedge CLK); idle(); #1;
    total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL ihit_cnt: got %0d want 3", stall_cnt); end
  endtask

  task automatic test_dwait();
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); idle(); mem_dREN = 1'b1;
      if (i >= 1) ex_pcsrc = 1'b1;
      if (i == 2) mem_halt = 1'b1;
      #1;
      total++; if (ctl !== C_FREEZE) begin bad++; $display("FAIL dwait_freeze%0d: got %b want %b", i, ctl, C_FREEZE); end
    end
    @(negedge CLK); idle(); mem_dREN = 1'b1; dhit = 1'b1; #1;
    total++; if (ctl !== C_ALL) begin bad++; $display("FAIL dwait_release: got %b want %b", ctl, C_ALL); end
    total++; if (stall_cnt !== 16'd7 || flush_cnt !== 16'd2) begin bad++;
      $display("FAIL dwait_cnt: got stall=%0d flush=%0d want 7 2", stall_cnt, flush_cnt); end
    @(negedge CLK); idle(); ex_pcsrc = 1'b1; #1;
    total++; if (ctl !== C_BRANCH) begin bad++; $display("FAIL dwait_back_run: got %b want %b", ctl, C_BRANCH); end
    @(negedge CLK); idle(); #1;
    total++; if (flush_cnt !== 16'd3 || stall_cnt !== 16'd7) begin bad++;
      $display("FAIL dwait_cnt2: got flush=%0d stall=%0d want 3 7", flush_cnt, stall_cnt); end
  endtask

  task automatic test_halt();
    @(negedge CLK); idle(); mem_halt = 1'b1; #1;
    total++; if (ctl !== C_ZERO || halt !== 1'b0) begin bad++;
      $display("FAIL halt_entry: got ctl=%b halt=%b want %b 0", ctl, halt, C_ZERO); end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); idle(); ex_pcsrc = i[0]; ihit = i[1]; mem_dREN = i[0]; #1;
      total++; if (ctl !== C_ZERO || halt !== 1'b1) begin bad++;
        $display("FAIL halt_hold%0d: got ctl=%b halt=%b want %b 1", i, ctl, halt, C_ZERO); end
    end
    total++; if (stall_cnt !== 16'd8 || flush_cnt !== 16'd3) begin bad++;
      $display("FAIL halt_cnt: got stall=%0d flush=%0d want 8 3", stall_cnt, flush_cnt); end
    @(negedge CLK); nRST = 1'b0; #1;
    total++; if (halt !== 1'b0 || stall_cnt !== '0 || flush_cnt !== '0) begin bad++;
      $display("FAIL halt_clear: got halt=%b stall=%0d flush=%0d want 0 0 0", halt, stall_cnt, flush_cnt); end
    @(negedge CLK); idle(); nRST = 1'b1; #1;
    total++; if (ctl !== C_ALL) begin bad++; $display("FAIL halt_rerun: got %b want %b", ctl, C_ALL); end
  endtask

  task automatic test_saturation();
    @(negedge CLK); idle(); ihit = 1'b0;
    repeat (10) @(negedge CLK);
    total++; if (stall_cnt !== 16'd10) begin bad++; $display("FAIL sat_mid: got %0d want 10", stall_cnt); end
    repeat ((1 << CNT_W) + 5 - 10) @(negedge CLK);
    total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_top: got %h want ffff", stall_cnt); end
    repeat (3) @(negedge CLK);
    total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %h want ffff", stall_cnt); end
  endtask

  initial begin
    idle();
    test_reset();
    test_loaduse();
    test_branch();
    test_dwait();
    test_halt();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
